// File: rtl/regfile_pkg.sv
// Shared sizing constants and the round-robin requester type for the
// register-file writeback path.
package regfile_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int NREG   = 32;

   localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } req_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits: set by issue-stage reservations, cleared by the
// edge on which the write actually lands in the register file.
module reg_scoreboard
   import regfile_pkg::*;
#(
   parameter int ADDR_W = regfile_pkg::ADDR_W,
   parameter int NREG   = regfile_pkg::NREG
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              set_en_i,
   input  logic [ADDR_W-1:0] set_rd_i,
   input  logic              clr_en_i,
   input  logic [ADDR_W-1:0] clr_rd_i,
   input  logic [ADDR_W-1:0] r1_i,
   input  logic [ADDR_W-1:0] r2_i,
   output logic              busy1_o,
   output logic              busy2_o
);

   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;

   // Next busy vector: a set on the same edge as a clear wins, so a fresh
   // reservation is never lost to an older write completing.
   always_comb begin
      busy_d = busy_q;
      for (int i = 1; i < NREG; i++) begin
         if (set_en_i && (set_rd_i == ADDR_W'(i))) begin
            busy_d[i] = 1'b1;
         end else if (clr_en_i && (clr_rd_i == ADDR_W'(i))) begin
            busy_d[i] = 1'b0;
         end else begin
            busy_d[i] = busy_q[i];
         end
      end
      busy_d[0] = 1'b0;
   end

   // Busy bit storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy1_o = busy_q[r1_i];
   assign busy2_o = busy_q[r2_i];

endmodule

// File: rtl/reg_file_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU
// (A) and load (B) writeback sources, with a registered write stage.
module reg_file_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int DATA_W = regfile_pkg::DATA_W,
   parameter int ADDR_W = regfile_pkg::ADDR_W,
   parameter int NREG   = regfile_pkg::NREG
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [ADDR_W-1:0] a_rd,
   input  logic [DATA_W-1:0] a_data,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic [ADDR_W-1:0] b_rd,
   input  logic [DATA_W-1:0] b_data,
   input  logic              rsv_en,
   input  logic [ADDR_W-1:0] rsv_rd,
   input  logic [ADDR_W-1:0] r1,
   input  logic [ADDR_W-1:0] r2,
   output logic              busy1,
   output logic              busy2,
   output logic              wr,
   output logic [ADDR_W-1:0] rd,
   output logic [DATA_W-1:0] write_data
);

   req_e              ptr_q;
   req_e              ptr_d;
   logic              grant_a_s;
   logic              grant_b_s;
   logic              wr_q;
   logic              wr_d;
   logic [ADDR_W-1:0] rd_q;
   logic [ADDR_W-1:0] rd_d;
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] data_d;

   // Grant selection; readies are held low while reset is asserted.
   always_comb begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
      if (!rst_n) begin
         grant_a_s = 1'b0;
         grant_b_s = 1'b0;
      end else if (a_valid && b_valid) begin
         grant_a_s = (ptr_q == REQ_A);
         grant_b_s = (ptr_q == REQ_B);
      end else begin
         grant_a_s = a_valid;
         grant_b_s = b_valid;
      end
   end

   assign a_ready = grant_a_s;
   assign b_ready = grant_b_s;

   // Pointer moves to the loser after any grant, and write-stage next state.
   always_comb begin
      ptr_d  = ptr_q;
      wr_d   = 1'b0;
      rd_d   = rd_q;
      data_d = data_q;
      if (grant_a_s) begin
         ptr_d = REQ_B;
         if (a_rd != ZERO_REG) begin
            wr_d   = 1'b1;
            rd_d   = a_rd;
            data_d = a_data;
         end else begin
            wr_d = 1'b0;
         end
      end else if (grant_b_s) begin
         ptr_d = REQ_A;
         if (b_rd != ZERO_REG) begin
            wr_d   = 1'b1;
            rd_d   = b_rd;
            data_d = b_data;
         end else begin
            wr_d = 1'b0;
         end
      end else begin
         ptr_d = ptr_q;
      end
   end

   // Pointer and write-port registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q  <= REQ_A;
         wr_q   <= 1'b0;
         rd_q   <= '0;
         data_q <= '0;
      end else begin
         ptr_q  <= ptr_d;
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         data_q <= data_d;
      end
   end

   assign wr         = wr_q;
   assign rd         = rd_q;
   assign write_data = data_q;

   // Clears follow the registered write so busy drops on the reg_file write edge.
   reg_scoreboard #(
      .ADDR_W (ADDR_W),
      .NREG   (NREG)
   ) u_scoreboard (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_en_i (rsv_en),
      .set_rd_i (rsv_rd),
      .clr_en_i (wr_q),
      .clr_rd_i (rd_q),
      .r1_i     (r1),
      .r2_i     (r2),
      .busy1_o  (busy1),
      .busy2_o  (busy2)
   );

endmodule

// File: doc/reg_file_wb_arbiter.md
Name: reg_file_wb_arbiter

Overview:
- Shares the register file's single write port (wr, rd, write_data) between two writeback sources: A = ALU result, B = memory-load result.
- Uses round-robin arbitration with a valid/ready handshake per source and a registered output stage.
- Holds a per-register busy scoreboard so issue logic can stall reads of registers with a write still in flight.
- Sits between the execute/memory stages and reg_file; its outputs drive reg_file's clk-synchronous write port directly.

Parameters:
- DATA_W, 32, write data width.
- ADDR_W, 5, register address width.
- NREG, 32, number of registers; must equal 2**ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a_valid  in  1  source A has a write pending.
- a_ready  out  1  source A write accepted this cycle.
- a_rd  in  ADDR_W  source A destination register.
- a_data  in  DATA_W  source A write data.
- b_valid  in  1  source B has a write pending.
- b_ready  out  1  source B write accepted this cycle.
- b_rd  in  ADDR_W  source B destination register.
- b_data  in  DATA_W  source B write data.
- rsv_en  in  1  issue stage reserves a destination register.
- rsv_rd  in  ADDR_W  register being reserved.
- r1  in  ADDR_W  read address 1 to check.
- r2  in  ADDR_W  read address 2 to check.
- busy1  out  1  register r1 has a write outstanding.
- busy2  out  1  register r2 has a write outstanding.
- wr  out  1  write enable to reg_file.
- rd  out  ADDR_W  write address to reg_file.
- write_data  out  DATA_W  write data to reg_file.

Behaviour:
- Reset (async, rst_n=0):
  - wr=0, rd=0, write_data=0.
  - All busy bits cleared.
  - Round-robin pointer = A.
  - a_ready=b_ready=0 while in reset.
  - Reset asserted mid-operation discards any staged write; no partial write reaches reg_file.
- Arbitration (combinational, every cycle):
  - Only one valid: that source is granted.
  - Both valid: the source the pointer selects is granted.
  - Neither valid: no grant.
  - a_ready/b_ready = grant for that source, same cycle. Transfer occurs when valid&&ready at the rising edge.
  - Pointer moves to the non-granted source after every grant, whether contended or not. Pointer holds when there is no grant.
  - Guaranteed fairness: under continuous contention, grants alternate A,B,A,B.
- Output stage (registered):
  - On a transfer with destination != 0: next edge sets wr=1 and latches rd/write_data from the winner.
  - Otherwise next edge sets wr=0; rd/write_data hold their previous values.
  - Latency: accept edge N -> wr high during cycle N..N+1 -> reg_file captures at edge N+1.
  - One write issued per cycle maximum; sustained throughput 1 write/cycle.
- Register 0:
  - A write to register 0 is accepted (ready=1) but suppressed: wr stays 0.
  - busy[0] is never set; busy1/busy2 for address 0 always read 0.
- Scoreboard (NREG bits):
  - Set: rsv_en=1 at an edge sets busy[rsv_rd] (rsv_rd != 0).
  - Clear: the edge where wr=1 clears busy[rd], which is the edge reg_file writes.
  - Same register set and cleared on the same edge: set wins (new reservation outstanding).
  - Reserving an already-busy register: stays busy, no count; one clear releases it.
  - busy1=busy[r1], busy2=busy[r2]: combinational from the registered bits, with no bypass of same-cycle set/clear.
- Source-side contract:
  - Sources hold rd/data stable while valid && !ready.
  - The block does not check or enforce this.

Decomposition:
- Shared package (regfile_pkg):
  - DATA_W, ADDR_W, NREG.
  - ZERO_REG constant (0).
  - Requester typedef enum {REQ_A, REQ_B} for the round-robin pointer.
- One sub-module: reg_scoreboard.
  - Contains the NREG busy bits, set/clear priority logic, and the two read-port lookups.
  - Instantiated once; arbitration and output stage stay in the top level.

Test Plan:
- Reset: assert rst_n=0 mid-run after staging a write -> wr=0, rd=0, write_data=0, busy1=busy2=0 immediately. No write occurs at the next edge after release.
- Single source: a_valid=1, a_rd=3, a_data=7 for one cycle -> a_ready=1 that cycle; next cycle wr=1, rd=3, write_data=7; following cycle wr=0. reg_file r1=3 then reads 7.
- Contention: a_valid=b_valid=1 held 4 cycles, with a_rd=5/b_rd=6 and data 0x11/0x22 -> grants A,B,A,B; wr sequence rd=5,6,5,6.
- Zero register: b_valid=1, b_rd=0, b_data=0xFFFF -> b_ready=1, wr stays 0; r1=0 -> busy1=0.
- Scoreboard: rsv_en=1, rsv_rd=9 -> next cycle busy1=1 with r1=9. Then A writes rd=9 -> busy1 drops after the edge where wr=1, rd=9.
- Set/clear collision: rsv_en=1, rsv_rd=4 on the same edge as wr=1, rd=4 -> busy[4] remains 1 after that edge (r2=4 -> busy2=1).
